// File: rtl/frame_builder.sv
// frame_builder: buffers one frame of payload from a valid/ready source and
// emits HEADER, CTRL, payload, CRC-16 and idle filler as a word-per-cycle stream.
//
// Ports:
//   clk_in       system clock, rising edge
//   rst_n        asynchronous active-low reset
//   s_data       payload word            (in, 16)
//   s_valid      payload word valid      (in)
//   s_last       final payload word      (in)
//   s_ready      payload accepted        (out)
//   ch_mask      channel mask, taken with the first word of a frame (in, 8)
//   crc_corrupt  invert CRC bit 0, taken with the final word (in)
//   data_out     framed stream           (out, 16)
//   frame_active HEADER through CRC      (out)
//   frame_done   pulse with the CRC word (out)
//   len_err      pulse when a frame fills without s_last (out)
module frame_builder #(
    parameter int          MAX_WORDS = 8,
    parameter logic [15:0] HEADER    = 16'hE0E0,
    parameter logic [15:0] IDLE_WORD = 16'h0000,
    parameter int          GAP_WORDS = 2,
    parameter logic [15:0] CRC_INIT  = 16'hFFFF
) (
    input  logic        clk_in,
    input  logic        rst_n,
    input  logic [15:0] s_data,
    input  logic        s_valid,
    input  logic        s_last,
    output logic        s_ready,
    input  logic [7:0]  ch_mask,
    input  logic        crc_corrupt,
    output logic [15:0] data_out,
    output logic        frame_active,
    output logic        frame_done,
    output logic        len_err
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LOAD = 3'd1;
    localparam logic [2:0] S_HDR  = 3'd2;
    localparam logic [2:0] S_CTRL = 3'd3;
    localparam logic [2:0] S_PAY  = 3'd4;
    localparam logic [2:0] S_CRC  = 3'd5;
    localparam logic [2:0] S_GAP  = 3'd6;

    localparam logic [3:0] MAX4 = 4'(MAX_WORDS);
    localparam logic [3:0] GAP4 = 4'(GAP_WORDS - 1);

    logic [2:0]  state;
    logic [3:0]  cnt;
    logic [3:0]  pidx;
    logic [3:0]  gap_cnt;
    logic [7:0]  mask;
    logic        corrupt;
    logic [15:0] crc_reg;
    logic [15:0] mem [MAX_WORDS];

    logic        xfer;
    logic [3:0]  wr_idx;
    logic [3:0]  cnt_next;
    logic        load_end;
    logic [15:0] rd_word;
    logic [15:0] ctrl_word;

    // CRC-16/CCITT over one word, MSB first, fully unrolled.
    function automatic logic [15:0] crc_step(
        input logic [15:0] c_in,
        input logic [15:0] d
    );
        logic [15:0] c;
        logic        fb;
        c = c_in;
        for (int b = 15; b >= 0; b--) begin
            fb = c[15] ^ d[b];
            c  = {c[14:0], 1'b0};
            if (fb) c = c ^ 16'h1021;
        end
        return c;
    endfunction

    // Gated by rst_n so ready drops the moment reset is asserted.
    assign s_ready   = rst_n && (state == S_IDLE || state == S_LOAD);
    assign xfer      = s_valid && s_ready;
    assign wr_idx    = (state == S_IDLE) ? 4'd0 : cnt;
    assign cnt_next  = wr_idx + 4'd1;
    assign load_end  = s_last || (cnt_next == MAX4);
    assign ctrl_word = {mask, 4'b0000, cnt};

    always_comb begin
        rd_word = IDLE_WORD;
        for (int i = 0; i < MAX_WORDS; i++) begin
            if (pidx == 4'(i)) rd_word = mem[i];
        end
    end

    // Payload store needs no reset: cnt bounds what is ever read back.
    always_ff @(posedge clk_in) begin
        if (xfer) begin
            for (int i = 0; i < MAX_WORDS; i++) begin
                if (wr_idx == 4'(i)) mem[i] <= s_data;
            end
        end
    end

    // data_out always reflects the current state's word, so each
    // transition loads the word belonging to the state being entered.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            cnt          <= 4'd0;
            pidx         <= 4'd0;
            gap_cnt      <= 4'd0;
            mask         <= 8'd0;
            corrupt      <= 1'b0;
            crc_reg      <= CRC_INIT;
            data_out     <= IDLE_WORD;
            frame_active <= 1'b0;
            frame_done   <= 1'b0;
            len_err      <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            len_err    <= 1'b0;
            unique case (state)
                S_IDLE, S_LOAD: begin
                    if (xfer) begin
                        cnt     <= cnt_next;
                        corrupt <= crc_corrupt;
                        if (state == S_IDLE) mask <= ch_mask;
                        if (load_end) begin
                            state        <= S_HDR;
                            data_out     <= HEADER;
                            frame_active <= 1'b1;
                            crc_reg      <= CRC_INIT;
                            pidx         <= 4'd0;
                            len_err      <= !s_last;
                        end else begin
                            state <= S_LOAD;
                        end
                    end
                end
                S_HDR: begin
                    state    <= S_CTRL;
                    data_out <= ctrl_word;
                    crc_reg  <= crc_step(crc_reg, ctrl_word);
                end
                S_CTRL, S_PAY: begin
                    if (state == S_PAY && pidx == cnt) begin
                        state      <= S_CRC;
                        data_out   <= crc_reg ^ {15'b0, corrupt};
                        frame_done <= 1'b1;
                    end else begin
                        state    <= S_PAY;
                        data_out <= rd_word;
                        crc_reg  <= crc_step(crc_reg, rd_word);
                        pidx     <= pidx + 4'd1;
                    end
                end
                S_CRC: begin
                    state        <= S_GAP;
                    data_out     <= IDLE_WORD;
                    frame_active <= 1'b0;
                    gap_cnt      <= GAP4;
                end
                S_GAP: begin
                    data_out <= IDLE_WORD;
                    if (gap_cnt == 4'd0) begin
                        state <= S_IDLE;
                        cnt   <= 4'd0;
                    end else begin
                        gap_cnt <= gap_cnt - 4'd1;
                    end
                end
                default: begin
                    state        <= S_IDLE;
                    data_out     <= IDLE_WORD;
                    frame_active <= 1'b0;
                end
            endcase
        end
    end

endmodule
